// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for the sequential signed divider.
// The host drives the request side; the divider drives results and status.
interface seq_divider_if #(
  parameter int DW = 10,
  parameter int SW = 5
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: unsigned restoring division on magnitudes,
// one quotient bit per clock, followed by sign correction and overflow saturation.
module seq_divider #(
  parameter int DW = 10,
  parameter int SW = 5
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dvd_reg;
  logic [SW-1:0] dvs_reg;
  logic [DW-1:0] q_mag;   // dividend magnitude shifts out, quotient bits shift in
  logic [SW-1:0] d_mag;
  logic [SW:0]   pr;      // partial remainder
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic          sign_r;

  logic [SW:0]   shifted;
  logic [SW+1:0] trial;
  logic [DW-1:0] fix_q;
  logic [SW-1:0] fix_r;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = {pr[SW-1:0], q_mag[DW-1]};
    trial   = {1'b0, shifted} - {2'b00, d_mag};
    fix_q   = sign_q ? -q_mag : q_mag;
    fix_r   = sign_r ? -pr[SW-1:0] : pr[SW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      dvd_reg         <= '0;
      dvs_reg         <= '0;
      q_mag           <= '0;
      d_mag           <= '0;
      pr              <= '0;
      cnt             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_reg  <= bus.dividend;
            dvs_reg  <= bus.divisor;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          sign_q <= dvd_reg[DW-1] ^ dvs_reg[SW-1];
          sign_r <= dvd_reg[DW-1];
          q_mag  <= dvd_reg[DW-1] ? -dvd_reg : dvd_reg;
          d_mag  <= dvs_reg[SW-1] ? -dvs_reg : dvs_reg;
          pr     <= '0;
          cnt    <= '0;
          if (dvs_reg == '0) begin
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b1;
            bus.overflow    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            state           <= DONE;
          end else begin
            state <= DIV;
          end
        end

        DIV: begin
          // Trial result's MSB set means the subtraction went negative: restore.
          if (trial[SW+1]) begin
            pr    <= shifted;
            q_mag <= {q_mag[DW-2:0], 1'b0};
          end else begin
            pr    <= trial[SW:0];
            q_mag <= {q_mag[DW-2:0], 1'b1};
          end
          if (cnt == CW'(DW - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FIX: begin
          bus.div_by_zero <= 1'b0;
          // Only -2^(DW-1) / -1 yields a positive magnitude with the MSB set.
          if (!sign_q && q_mag[DW-1]) begin
            bus.overflow  <= 1'b1;
            bus.quotient  <= {1'b0, {(DW-1){1'b1}}};
            bus.remainder <= '0;
          end else begin
            bus.overflow  <= 1'b0;
            bus.quotient  <= fix_q;
            bus.remainder <= fix_r;
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: sign combinations, remainder
// sign, divide-by-zero, overflow saturation, ignored start and mid-divide reset.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.DW(10), .SW(5)) bus ();

  seq_divider #(.DW(10), .SW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 16'(bus.busy), 16'h0);
    check({tag, "_done"}, 16'(bus.done), 16'h0);
    check({tag, "_quot"}, 16'(bus.quotient), 16'h0);
    check({tag, "_rem"},  16'(bus.remainder), 16'h0);
    check({tag, "_dbz"},  16'(bus.div_by_zero), 16'h0);
    check({tag, "_ovf"},  16'(bus.overflow), 16'h0);
  endtask

  // Launch one divide from IDLE and check latency, busy length and results.
  task automatic do_div(input string tag, input logic [9:0] a, input logic [4:0] b,
                        input logic [9:0] eq, input logic [4:0] er,
                        input logic edz, input logic eov, input int elat);
    int lat;
    int bcnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    lat  = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) bcnt++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(elat));
    check({tag, "_busy_cycles"}, 16'(bcnt), 16'(elat));
    check({tag, "_busy_at_done"}, 16'(bus.busy), 16'h0);
    check({tag, "_quot"}, 16'(bus.quotient), 16'(eq));
    check({tag, "_rem"},  16'(bus.remainder), 16'(er));
    check({tag, "_dbz"},  16'(bus.div_by_zero), 16'(edz));
    check({tag, "_ovf"},  16'(bus.overflow), 16'(eov));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 16'(bus.done), 16'h0);
    check({tag, "_quot_hold"}, 16'(bus.quotient), 16'(eq));
  endtask

  initial begin
    int pulses;
    logic [9:0] cap_q;
    logic [4:0] cap_r;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    do_div("p8_d4",      10'h008, 5'h04, 10'h002, 5'h00, 1'b0, 1'b0, 12);
    do_div("m15_dm3",    10'h3F1, 5'h1D, 10'h005, 5'h00, 1'b0, 1'b0, 12);
    do_div("p15_dm3",    10'h00F, 5'h1D, 10'h3FB, 5'h00, 1'b0, 1'b0, 12);
    do_div("m7_d2",      10'h3F9, 5'h02, 10'h3FD, 5'h1F, 1'b0, 1'b0, 12);
    do_div("p11_dm16",   10'h00B, 5'h10, 10'h000, 5'h0B, 1'b0, 1'b0, 12);
    do_div("m100_d7",    10'h39C, 5'h07, 10'h3F2, 5'h1E, 1'b0, 1'b0, 12);
    do_div("p511_dm16",  10'h1FF, 5'h10, 10'h3E1, 5'h0F, 1'b0, 1'b0, 12);
    do_div("p100_d0",    10'h064, 5'h00, 10'h000, 5'h00, 1'b1, 1'b0, 1);
    do_div("m512_dm1",   10'h200, 5'h1F, 10'h1FF, 5'h00, 1'b0, 1'b1, 12);
    do_div("m512_d1",    10'h200, 5'h01, 10'h200, 5'h00, 1'b0, 1'b0, 12);

    // Second start while busy must be dropped: 100/7 = 14 r 2 only.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd100; bus.divisor = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd50; bus.divisor = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    cap_q  = '0;
    cap_r  = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        cap_q = bus.quotient;
        cap_r = bus.remainder;
      end
    end
    check("ignored_start_pulses", 16'(pulses), 16'h1);
    check("ignored_start_quot", 16'(cap_q), 16'h00E);
    check("ignored_start_rem",  16'(cap_r), 16'h002);

    // Reset at cycle 5 of a divide aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd123; bus.divisor = 5'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 16'(pulses), 16'h0);

    do_div("after_abort", 10'd123, 5'd5, 10'h018, 5'h03, 1'b0, 1'b0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
